main_mem_ctrl: RTL

//   Parametrised, clocked main memory with a valid/ready request port and a fixed-latency response port.

---
 rtl/main_mem_pkg.sv | 20 ++
 rtl/main_mem_if.sv | 33 +++
 rtl/main_mem_array.sv | 44 ++++
 rtl/main_mem_ctrl.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/main_mem_pkg.sv
// main_mem_pkg: shared types and constants for the main memory controller.
//   state_t        controller FSM states (IDLE, WAIT, RESP)
//   PRELOAD_WORD0  value forced into word 0 during reset when MAIN_MEM_PRELOAD_EN is defined
//   *_DEF          default parameter values for the controller, interface and array
package main_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [31:0] PRELOAD_WORD0 = 32'h0022_1800;

  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned DEPTH_DEF   = 128;
  localparam int unsigned LATENCY_DEF = 2;

endpackage

// File: rtl/main_mem_if.sv
// main_mem_if: request/response bus between a requester (master) and main_mem_ctrl (slave).
//   req_valid/req_ready      request handshake; accept = valid & ready
//   req_write/addr/wdata/be  request payload (word address, byte enables)
//   resp_valid               one-cycle completion pulse
//   resp_rdata/resp_err      response payload, qualified by resp_valid
interface main_mem_if
  import main_mem_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  resp_valid;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/main_mem_array.sv
// main_mem_array: DEPTH x DATA_W storage with synchronous byte-enabled write and registered read.
//   clk      rising-edge clock
//   rst      blocks writes; with MAIN_MEM_PRELOAD_EN defined, forces word 0 to PRELOAD_WORD0
//   en_i     access strobe (one access per strobe)
//   we_i     1 = write bytes selected by be_i, 0 = read into rdata_o
//   addr_i   word index, must be < DEPTH
//   wdata_i  write data; be_i byte enables (bit i covers bits [8i+7:8i])
//   rdata_o  registered read data, updated only on read accesses
// Contents are never cleared, so the array can map onto block RAM in the default build.
module main_mem_array
  import main_mem_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_i,
  input  logic                we_i,
  input  logic [IDX_W-1:0]    addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] be_i,
  output logic [DATA_W-1:0]   rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i && we_i && !rst) begin
      for (int unsigned i = 0; i < DATA_W/8; i++) begin
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
`ifdef MAIN_MEM_PRELOAD_EN
    if (rst) mem_q[0] <= DATA_W'(PRELOAD_WORD0);
`endif
    if (en_i && !we_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/main_mem_ctrl.sv
// main_mem_ctrl: single-outstanding memory controller with fixed response latency.
//   clk   rising-edge clock
//   rst   asynchronous active-high reset; drops any transaction in flight
//   bus   main_mem_if.slave: valid/ready request port, one-cycle resp_valid pulse
// A request accepted at edge n produces resp_valid in cycle n+LATENCY; the next
// accept is possible at edge n+LATENCY+1. Addresses >= DEPTH (full ADDR_W compare)
// return resp_err=1 with rdata 0 and no array access.
// Optional feature: MAIN_MEM_PRELOAD_EN (word 0 forced to PRELOAD_WORD0 during reset).
module main_mem_ctrl
  import main_mem_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned LATENCY = LATENCY_DEF
) (
  input  logic      clk,
  input  logic      rst,
  main_mem_if.slave bus
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);
  localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W + 1)'(DEPTH);

  if (LATENCY < 1) begin : g_lat_chk
    $error("main_mem_ctrl: LATENCY must be >= 1");
  end
  if (DATA_W % 8 != 0) begin : g_dw_chk
    $error("main_mem_ctrl: DATA_W must be a multiple of 8");
  end

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [DATA_W-1:0] resp_rdata_q;

  logic              accept;
  logic              enter_resp;
  logic [ADDR_W-1:0] a_addr;
  logic              a_write;
  logic [DATA_W-1:0] a_wdata;
  logic [BE_W-1:0]   a_be;
  logic              a_in_range;
  logic              addr_q_ok;
  logic [DATA_W-1:0] arr_rdata;

  assign bus.req_ready = (state_q == IDLE) & ~rst;
  assign accept        = bus.req_valid & bus.req_ready;

  // The array is accessed on the edge that enters RESP. With LATENCY==1 that edge
  // is the accept edge itself, so the live request is used instead of the capture.
  always_comb begin
    if (state_q == IDLE) begin
      a_addr     = bus.req_addr;
      a_write    = bus.req_write;
      a_wdata    = bus.req_wdata;
      a_be       = bus.req_be;
      enter_resp = accept && (LATENCY == 1);
    end else begin
      a_addr     = addr_q;
      a_write    = write_q;
      a_wdata    = wdata_q;
      a_be       = be_q;
      enter_resp = (state_q == WAIT) && (cnt_q == CNT_LAST);
    end
  end

  assign a_in_range = {1'b0, a_addr} < DEPTH_X;
  assign addr_q_ok  = {1'b0, addr_q} < DEPTH_X;

  main_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .en_i    (enter_resp & a_in_range),
    .we_i    (a_write),
    .addr_i  (a_addr[IDX_W-1:0]),
    .wdata_i (a_wdata),
    .be_i    (a_be),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      be_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q  <= bus.req_addr;
            write_q <= bus.req_write;
            wdata_q <= bus.req_wdata;
            be_q    <= bus.req_be;
            if (LATENCY == 1) begin
              state_q <= RESP;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_W'(1);
            end
          end
        end
        WAIT: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= RESP;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RESP: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b1;
          resp_err_q   <= ~addr_q_ok;
          resp_rdata_q <= (write_q || !addr_q_ok) ? '0 : arr_rdata;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;

endmodule
